// File: rtl/k2p_pkg.sv
// k2p_pkg: shared opcodes, FSM states, destination codes and instruction field positions.
package k2p_pkg;
   typedef enum logic [2:0] {
      OP_ALU, OP_LDI, OP_JC, OP_STORE, OP_JMP, OP_LOAD, OP_JZ, OP_HALT
   } op_e;
   typedef enum logic {ST_RUN, ST_HALT} state_e;
   localparam logic [1:0] D_RA = 2'd0;
   localparam logic [1:0] D_RB = 2'd1;
   localparam logic [1:0] D_RO = 2'd2;
   localparam logic [1:0] D_NONE = 2'd3;
   function automatic int pos_j(input int imm_w);
      return imm_w + 4;
   endfunction
   function automatic int pos_c(input int imm_w);
      return imm_w + 3;
   endfunction
   function automatic int pos_d1(input int imm_w);
      return imm_w + 2;
   endfunction
   function automatic int pos_d0(input int imm_w);
      return imm_w + 1;
   endfunction
   function automatic int pos_sreg(input int imm_w);
      return imm_w;
   endfunction
endpackage

// File: rtl/k2p_alu.sv
// k2p_alu: DATA_W-bit add/subtract with carry-out (no-borrow on subtract) and zero flag.
module k2p_alu #(
   parameter int DATA_W = 8
) (
   input  logic [DATA_W-1:0] a,
   input  logic [DATA_W-1:0] b,
   input  logic              sub,
   output logic [DATA_W-1:0] result,
   output logic              carry_out,
   output logic              zero
);
   logic [DATA_W:0] sum;
   always_comb begin
      sum = {1'b0, a} + {1'b0, sub ? ~b : b} + (DATA_W+1)'(sub);
      result = sum[DATA_W-1:0];
      carry_out = sum[DATA_W];
      zero = result == '0;
   end
endmodule

// File: rtl/k2p_core.sv
// k2p_core: parametrised single-cycle accumulator core with RUN/HALT FSM and run_en stall.
// Define K2P_DMEM_EN to include the data memory; otherwise STORE is a no-op and LOAD returns 0.
module k2p_core
   import k2p_pkg::*;
#(
   parameter int DATA_W = 8,
   parameter int PC_W   = 4,
   parameter int IMM_W  = 3
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              run_en,
   input  logic [IMM_W+4:0]  instr,
   output logic [PC_W-1:0]   pc,
   output logic [DATA_W-1:0] reg_a,
   output logic [DATA_W-1:0] reg_b,
   output logic [DATA_W-1:0] reg_o,
   output logic              carry,
   output logic              zero,
   output logic              halted
);
   logic [PC_W-1:0] pc_q, pc_d, pc_inc, pc_imm;
   logic [DATA_W-1:0] ra_q, ra_d, rb_q, rb_d, ro_q, ro_d;
   logic [DATA_W-1:0] imm_x, alu_res, ld_val, wval;
   logic carry_q, carry_d, zero_q, zero_d, halted_q, halted_d;
   logic alu_c, alu_z, en, wr;
   state_e state_q, state_d;
   op_e op;
   logic [1:0] d;
   logic [IMM_W-1:0] imm;

   assign op = op_e'({instr[pos_j(IMM_W)], instr[pos_c(IMM_W)], instr[pos_sreg(IMM_W)]});
   assign d = {instr[pos_d1(IMM_W)], instr[pos_d0(IMM_W)]};
   assign imm = instr[IMM_W-1:0];
   assign imm_x = DATA_W'(imm);
   assign pc_imm = PC_W'(imm);
   assign pc_inc = pc_q + PC_W'(1);
   assign en = run_en && state_q == ST_RUN;

   k2p_alu #(.DATA_W(DATA_W)) u_alu (
      .a(ra_q), .b(rb_q), .sub(imm[IMM_W-1]),
      .result(alu_res), .carry_out(alu_c), .zero(alu_z)
   );

`ifdef K2P_DMEM_EN
   localparam int MEM_N = 2**IMM_W;
   logic [DATA_W-1:0] mem_q [MEM_N];
   logic mem_we;
   assign mem_we = en && op == OP_STORE;
   assign ld_val = mem_q[imm];
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) for (int i = 0; i < MEM_N; i++) mem_q[i] <= '0;
      else if (mem_we) mem_q[imm] <= ra_q;
   end
`else
   assign ld_val = '0;
`endif

   always_comb begin
      pc_d = pc_q;
      ra_d = ra_q;
      rb_d = rb_q;
      ro_d = ro_q;
      carry_d = carry_q;
      zero_d = zero_q;
      state_d = state_q;
      halted_d = halted_q;
      wr = en && (op == OP_ALU || op == OP_LDI || op == OP_LOAD);
      wval = op == OP_ALU ? alu_res : op == OP_LDI ? imm_x : ld_val;
      if (en) begin
         pc_d = op == OP_JMP || (op == OP_JC && carry_q) || (op == OP_JZ && zero_q) ? pc_imm :
                op == OP_HALT ? pc_q : pc_inc;
         carry_d = op == OP_ALU ? alu_c : carry_q;
         zero_d = op == OP_ALU ? alu_z : zero_q;
         state_d = op == OP_HALT ? ST_HALT : state_q;
         halted_d = op == OP_HALT ? 1'b1 : halted_q;
      end
      // RO always takes RA (K2 semantic); LOAD never targets RO
      if (wr) begin
         case (d)
            D_RA: ra_d = wval;
            D_RB: rb_d = wval;
            D_RO: ro_d = op == OP_LOAD ? ro_q : ra_q;
            D_NONE: ;
         endcase
      end
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pc_q <= '0;
         ra_q <= '0;
         rb_q <= '0;
         ro_q <= '0;
         carry_q <= 1'b0;
         zero_q <= 1'b0;
         halted_q <= 1'b0;
         state_q <= ST_RUN;
      end else begin
         pc_q <= pc_d;
         ra_q <= ra_d;
         rb_q <= rb_d;
         ro_q <= ro_d;
         carry_q <= carry_d;
         zero_q <= zero_d;
         halted_q <= halted_d;
         state_q <= state_d;
      end
   end

   assign pc = pc_q;
   assign reg_a = ra_q;
   assign reg_b = rb_q;
   assign reg_o = ro_q;
   assign carry = carry_q;
   assign zero = zero_q;
   assign halted = halted_q;
endmodule
